alu_cmd_issue: RTL

// Command buffer and result register wrapped around the combinational Select ALU.

---
 rtl/alu_cmd_issue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue
// Command buffer and result register wrapped around a combinational Select ALU.
// Commands {select, a, b} arrive over a valid/ready handshake and are queued in a
// DEPTH-entry FIFO. The FIFO head drives the ALU; the ALU output is captured into a
// result register that is offered downstream over a second valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   flush                       sync clear of FIFO and result valid
//   in_valid/in_ready           command handshake (in_ready = !full)
//   in_select/in_a/in_b         command fields
//   alu_select/alu_a/alu_b      FIFO head to ALU (0 when empty)
//   alu_x                       combinational ALU result
//   res_valid/res_ready         result handshake
//   res_x/res_select/res_zero   captured result, its op code, zero flag
//   count                       FIFO occupancy
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int SW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SW-1:0]          in_select,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  output logic [SW-1:0]          alu_select,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  input  logic [W-1:0]           alu_x,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_x,
  output logic [SW-1:0]          res_select,
  output logic                   res_zero,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SW-1:0] sel_mem_q [DEPTH];
  logic [W-1:0]  a_mem_q   [DEPTH];
  logic [W-1:0]  b_mem_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_x_q, res_x_d;
  logic [SW-1:0] res_select_q, res_select_d;
  logic          res_zero_q, res_zero_d;

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // No full bypass: a pop in the same cycle does not open in_ready.
  assign in_ready = !full;
  assign push     = in_valid & in_ready;
  assign pop      = !empty & (!res_valid_q | res_ready);

  // Head is only visible once registered; no write-through when empty.
  assign alu_select = empty ? '0 : sel_mem_q[rd_ptr_q];
  assign alu_a      = empty ? '0 : a_mem_q[rd_ptr_q];
  assign alu_b      = empty ? '0 : b_mem_q[rd_ptr_q];

  assign res_valid  = res_valid_q;
  assign res_x      = res_x_q;
  assign res_select = res_select_q;
  assign res_zero   = res_zero_q;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    res_valid_d  = res_valid_q;
    res_x_d      = res_x_q;
    res_select_d = res_select_q;
    res_zero_d   = res_zero_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      res_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop) begin
        res_valid_d  = 1'b1;
        res_x_d      = alu_x;
        res_select_d = alu_select;
        res_zero_d   = (alu_x == '0);
      end else if (res_valid_q && res_ready) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_x_q      <= '0;
      res_select_q <= '0;
      res_zero_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_x_q      <= res_x_d;
      res_select_q <= res_select_d;
      res_zero_q   <= res_zero_d;
    end
  end

  // Storage needs no reset: entries are only observed while count marks them live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      sel_mem_q[wr_ptr_q] <= in_select;
      a_mem_q[wr_ptr_q]   <= in_a;
      b_mem_q[wr_ptr_q]   <= in_b;
    end
  end

endmodule
